// File: rtl/tlc_pkg.sv
// Shared types for the timed traffic-light controller: state encoding, lamp vector, lamp decode.
package tlc_pkg;

    typedef enum logic [2:0] {
        HG     = 3'd0,
        HY     = 3'd1,
        AR_HF  = 3'd2,
        FG     = 3'd3,
        FY     = 3'd4,
        AR_FH  = 3'd5,
        AR_EMG = 3'd6,
        FLASH  = 3'd7
    } state_t;

    typedef struct packed {
        logic HR;
        logic HY;
        logic HG;
        logic FR;
        logic FY;
        logic FG;
    } lamp_t;

    // Steady lamp pattern per state; FLASH gives its lit phase, the top blanks the dark phase.
    function automatic lamp_t lamp_of(state_t s);
        lamp_t l;
        l = '0;
        case (s)
            HG:      begin l.HG = 1'b1; l.FR = 1'b1; end
            HY:      begin l.HY = 1'b1; l.FR = 1'b1; end
            FG:      begin l.HR = 1'b1; l.FG = 1'b1; end
            FY:      begin l.HR = 1'b1; l.FY = 1'b1; end
            FLASH:   begin l.HY = 1'b1; l.FR = 1'b1; end
            default: begin l.HR = 1'b1; l.FR = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_ctrl_timed_if.sv
// Sensor/emergency inputs and lamp/status outputs of the intersection controller.
// Optional Flash input exists only when TLC_FLASH_EN is defined.
interface traffic_ctrl_timed_if #(
    parameter int unsigned CNT_W = 8
);
    logic             C;
    logic             Emergency;
`ifdef TLC_FLASH_EN
    logic             Flash;
`endif
    logic             HR;
    logic             HY;
    logic             HG;
    logic             FR;
    logic             FY;
    logic             FG;
    logic             ST;
    logic [CNT_W-1:0] dwell;

    modport master (
        output C, Emergency,
`ifdef TLC_FLASH_EN
        output Flash,
`endif
        input  HR, HY, HG, FR, FY, FG, ST, dwell
    );

    modport slave (
        input  C, Emergency,
`ifdef TLC_FLASH_EN
        input  Flash,
`endif
        output HR, HY, HG, FR, FY, FG, ST, dwell
    );
endinterface

// File: rtl/tlc_dwell_timer.sv
// Saturating dwell counter: clear forces zero, hold freezes, otherwise counts up to all-ones.
module tlc_dwell_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hold,
    output logic [CNT_W-1:0] dwell
);
    localparam logic [CNT_W-1:0] DWELL_MAX = '1;

    always_ff @(posedge Clk) begin
        if (!reset || clear) begin
            dwell <= '0;
        end else if (!hold && (dwell != DWELL_MAX)) begin
            dwell <= dwell + CNT_W'(1);
        end
    end
endmodule

// File: rtl/traffic_ctrl_timed.sv
// Highway/farm-road controller with internal dwell timer, all-red clearance and emergency preemption.
// Define TLC_FLASH_EN to add the Flash input and the flashing-yellow/red FLASH state.
module traffic_ctrl_timed
    import tlc_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned T_HG_MIN = 10,
    parameter int unsigned T_FG_MAX = 6,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 2
) (
    input logic                  Clk,
    input logic                  reset,
    traffic_ctrl_timed_if.slave  bus
);
    localparam logic [CNT_W-1:0] HG_MIN_M1 = CNT_W'(T_HG_MIN - 1);
    localparam logic [CNT_W-1:0] FG_MAX_M1 = CNT_W'(T_FG_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_M1     = CNT_W'(T_ALLRED - 1);

    state_t           state;
    state_t           state_n;
    logic             emg_pend;
    logic             emg_pend_n;
    logic             emg;
    logic             change;
    logic             st;
    lamp_t            lamp;
    lamp_t            lamp_n;
    logic [CNT_W-1:0] dwell;
    logic             tmr_clear;
    logic             tmr_hold;

    assign emg    = emg_pend | bus.Emergency;
    assign change = (state_n != state);

    // AR_EMG keeps its release count at zero for as long as Emergency is asserted.
    assign tmr_hold  = (state == AR_EMG) && bus.Emergency;
    assign tmr_clear = change || (tmr_hold && (dwell != '0));

    tlc_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
        .Clk   (Clk),
        .reset (reset),
        .clear (tmr_clear),
        .hold  (tmr_hold),
        .dwell (dwell)
    );

    always_comb begin
        state_n    = state;
        emg_pend_n = emg_pend;
        unique case (state)
            HG: begin
                if (emg)                                     state_n = HY;
`ifdef TLC_FLASH_EN
                else if (bus.Flash)                          state_n = FLASH;
`endif
                else if (bus.C && (dwell >= HG_MIN_M1))      state_n = HY;
            end
            HY:     if (dwell == YEL_M1) state_n = emg ? AR_EMG : AR_HF;
            AR_HF:  if (dwell == AR_M1)  state_n = emg ? AR_EMG : FG;
            FG:     if (emg || !bus.C || (dwell == FG_MAX_M1)) state_n = FY;
            FY:     if (dwell == YEL_M1) state_n = emg ? AR_EMG : AR_FH;
            AR_FH:  if (dwell == AR_M1)  state_n = emg ? AR_EMG : HG;
            AR_EMG: if (!bus.Emergency && (dwell == AR_M1)) state_n = HG;
`ifdef TLC_FLASH_EN
            FLASH: begin
                if (bus.Emergency)   state_n = AR_EMG;
                else if (!bus.Flash) state_n = AR_FH;
            end
`endif
            default: state_n = HG;
        endcase
        // A request is consumed on entry to AR_EMG and cannot re-arm while being serviced.
        emg_pend_n = ((state == AR_EMG) || (state_n == AR_EMG)) ? 1'b0 : emg;
    end

`ifdef TLC_FLASH_EN
    logic [CNT_W-1:0] fcnt;
    logic [CNT_W-1:0] fcnt_n;
    logic             flash_on;
    logic             flash_on_n;

    // Blink phase for FLASH: lit on entry, toggles every T_YELLOW cycles.
    always_comb begin
        fcnt_n     = fcnt;
        flash_on_n = flash_on;
        if (state_n == FLASH) begin
            if (state != FLASH) begin
                fcnt_n     = '0;
                flash_on_n = 1'b1;
            end else if (fcnt == YEL_M1) begin
                fcnt_n     = '0;
                flash_on_n = !flash_on;
            end else begin
                fcnt_n = fcnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            fcnt     <= '0;
            flash_on <= 1'b1;
        end else begin
            fcnt     <= fcnt_n;
            flash_on <= flash_on_n;
        end
    end

    always_comb begin
        lamp_n = lamp_of(state_n);
        if ((state_n == FLASH) && !flash_on_n) lamp_n = '0;
    end
`else
    always_comb begin
        lamp_n = lamp_of(state_n);
    end
`endif

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state    <= HG;
            emg_pend <= 1'b0;
            st       <= 1'b1;
            lamp     <= lamp_of(HG);
        end else begin
            state    <= state_n;
            emg_pend <= emg_pend_n;
            st       <= change;
            lamp     <= lamp_n;
        end
    end

    assign bus.HR    = lamp.HR;
    assign bus.HY    = lamp.HY;
    assign bus.HG    = lamp.HG;
    assign bus.FR    = lamp.FR;
    assign bus.FY    = lamp.FY;
    assign bus.FG    = lamp.FG;
    assign bus.ST    = st;
    assign bus.dwell = dwell;

    // Every non-flash state lights exactly one lamp per road.
    lamp_onehot: assert property (@(posedge Clk) disable iff (!reset)
        (state == FLASH) ||
        ($onehot({lamp.HR, lamp.HY, lamp.HG}) && $onehot({lamp.FR, lamp.FY, lamp.FG})));
endmodule

// File: tb/tb_traffic_ctrl_timed.sv
// Randomized + directed bench for traffic_ctrl_timed against a phase/elapsed-time reference model.
module tb_traffic_ctrl_timed;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned T_HG_MIN = 10;
    localparam int unsigned T_FG_MAX = 6;
    localparam int unsigned T_YELLOW = 3;
    localparam int unsigned T_ALLRED = 2;
    localparam int          SAT      = (1 << CNT_W) - 1;

    logic Clk = 1'b0;
    logic reset;
    always #5 Clk = ~Clk;

    traffic_ctrl_timed_if #(.CNT_W(CNT_W)) bus ();

    traffic_ctrl_timed #(
        .CNT_W(CNT_W), .T_HG_MIN(T_HG_MIN), .T_FG_MAX(T_FG_MAX),
        .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef enum {M_HG, M_HY, M_ARHF, M_FG, M_FY, M_ARFH, M_EMG, M_FL} phase_t;

    phase_t ph = M_HG;
    int     t = 0;
    bit     pend = 1'b0;
    bit     st_exp = 1'b1;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Expected lamps as {HR,HY,HG,FR,FY,FG}.
    function automatic logic [5:0] exp_lamps();
        case (ph)
            M_HG:    return 6'b001_100;
            M_HY:    return 6'b010_100;
            M_FG:    return 6'b100_001;
            M_FY:    return 6'b100_010;
            M_FL:    return (((t / T_YELLOW) % 2) == 0) ? 6'b010_100 : 6'b000_000;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic model(input bit r, input bit c, input bit e, input bit f);
        phase_t nx;
        bit     emg;
        if (!r) begin
            ph = M_HG; t = 0; pend = 1'b0; st_exp = 1'b1;
            return;
        end
        emg = pend || e;
        nx  = ph;
        case (ph)
            M_HG:   if (emg) nx = M_HY;
                    else if (f) nx = M_FL;
                    else if (c && (t + 1 >= int'(T_HG_MIN))) nx = M_HY;
            M_HY:   if (t + 1 == int'(T_YELLOW)) nx = emg ? M_EMG : M_ARHF;
            M_ARHF: if (t + 1 == int'(T_ALLRED)) nx = emg ? M_EMG : M_FG;
            M_FG:   if (emg || !c || (t + 1 == int'(T_FG_MAX))) nx = M_FY;
            M_FY:   if (t + 1 == int'(T_YELLOW)) nx = emg ? M_EMG : M_ARFH;
            M_ARFH: if (t + 1 == int'(T_ALLRED)) nx = emg ? M_EMG : M_HG;
            M_EMG:  if (!e && (t + 1 == int'(T_ALLRED))) nx = M_HG;
            M_FL:   if (e) nx = M_EMG; else if (!f) nx = M_ARFH;
            default: nx = M_HG;
        endcase
        pend   = ((ph == M_EMG) || (nx == M_EMG)) ? 1'b0 : emg;
        st_exp = (nx != ph);
        if ((nx != ph) || ((ph == M_EMG) && e)) t = 0;
        else t++;
        ph = nx;
    endtask

    task automatic step(input bit r, input bit c, input bit e, input bit f);
        logic [2:0] hr;
        logic [2:0] fr;
        reset         = r;
        bus.C         = c;
        bus.Emergency = e;
`ifdef TLC_FLASH_EN
        bus.Flash     = f;
`endif
        @(posedge Clk);
        #1;
        cyc++;
`ifdef TLC_FLASH_EN
        model(r, c, e, f);
`else
        model(r, c, e, 1'b0);
`endif
        check("lamps", 32'({bus.HR, bus.HY, bus.HG, bus.FR, bus.FY, bus.FG}), 32'(exp_lamps()));
        check("st", 32'(bus.ST), 32'(st_exp));
        check("dwell", 32'(bus.dwell), 32'((t > SAT) ? SAT : t));
        if (ph != M_FL) begin
            hr = {bus.HR, bus.HY, bus.HG};
            fr = {bus.FR, bus.FY, bus.FG};
            check("onehot", 32'($onehot(hr) && $onehot(fr)), 32'd1);
        end
    endtask

    // Runs with the given C until the model reaches phase p with elapsed time tt.
    task automatic wait_for(input phase_t p, input int tt, input bit c);
        int n;
        n = 0;
        while (!((ph == p) && (t == tt)) && (n < 300)) begin
            step(1'b1, c, 1'b0, 1'b0);
            n++;
        end
        if (n >= 300) check("wait_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int e_left;
        int f_left;
        bit e;
        bit f;
        reset         = 1'b0;
        bus.C         = 1'b0;
        bus.Emergency = 1'b0;
`ifdef TLC_FLASH_EN
        bus.Flash     = 1'b0;
`endif
        // Reset, then idle highway green long enough to saturate dwell.
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (300) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Constant farm demand: full cycle back to HG.
        repeat (45) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Farm car leaves early in FG.
        wait_for(M_FG, 2, 1'b1);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0);

        // One-cycle emergency at the start of FG.
        wait_for(M_FG, 0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Long emergency from early HG.
        wait_for(M_HG, 1, 1'b0);
        repeat (20) step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of farm yellow.
        wait_for(M_FY, 1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

`ifdef TLC_FLASH_EN
        wait_for(M_HG, 0, 1'b0);
        repeat (15) step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized traffic, emergencies, resets and flash requests.
        e_left = 0;
        f_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (e_left > 0) begin
                e = 1'b1; e_left--;
            end else if (($urandom % 60) == 0) begin
                e = 1'b1; e_left = int'($urandom_range(0, 24));
            end else begin
                e = 1'b0;
            end
            if (f_left > 0) begin
                f = 1'b1; f_left--;
            end else if (($urandom % 80) == 0) begin
                f = 1'b1; f_left = int'($urandom_range(0, 20));
            end else begin
                f = 1'b0;
            end
            step(($urandom % 200) != 0, ($urandom % 4) != 0, e, f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
